life_generation_ctrl: RTL
=========================

Name: life_generation_ctrl

Overview:
- Sequencer for the three-input neighbour-count adder path; computes one Game of Life generation over a ROWS x COLS grid held in registers.
- Walks cells in raster order, one cell per clock.
- Per cell: forms three 2-bit column sums, adds them into a 4-bit life count, applies the rule, and buffers the result.
- Commits the new generation atomically, then reports done; sits between the host load/read interface and the grid datapath.

Parameters:
- ROWS, 8, number of grid rows (2..16)
- COLS, 8, number of grid columns, also row word width (2..32)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request one generation; accepted only in IDLE
- wr_en  in  1  write one row of the current grid; honoured only in IDLE
- wr_row  in  clog2(ROWS)  row index for write
- wr_data  in  COLS  row data; bit c = column c, 1 = alive
- rd_row  in  clog2(ROWS)  row index for read
- rd_data  out  COLS  current-grid row rd_row, combinational
- busy  out  1  high while state != IDLE
- done  out  1  one-cycle pulse after commit
- gen_count  out  16  generations completed, wraps 0xFFFF->0
- pop  out  clog2(ROWS*COLS+1)  live-cell count of last committed generation

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; current grid, next buffer and row/col counters = 0.
  - busy=0, done=0, gen_count=0, pop=0.
  - Takes effect immediately, including mid-COMPUTE; the partial generation is discarded.
- States: IDLE, COMPUTE, COMMIT.
- IDLE:
  - wr_en=1 writes wr_data into row wr_row at the clock edge.
  - start=1 moves to COMPUTE with r=0, c=0 and clears the population accumulator.
  - wr_en and start in the same cycle: the write is applied at that edge; compute sees the post-write grid.
  - Out-of-range wr_row (>= ROWS) is ignored.
- COMPUTE (one cell (r,c) per cycle):
  - Column sum s_k for k in {c-1, c, c+1}: 2-bit count of alive cells in rows r-1, r, r+1 of column k.
  - Cells outside the grid read as dead; no wrap-around.
  - life = s0 + s1 + s2, 4 bits, range 0..9, including the cell itself.
  - next(r,c) = 1 if life==3, or if life==4 and cell(r,c) alive; else 0.
  - next(r,c) is written to the next buffer; the population accumulator adds next(r,c).
  - Counter advances c, then r. After cell (ROWS-1, COLS-1), state goes to COMMIT.
  - The current grid is not modified during COMPUTE.
- COMMIT (one cycle):
  - next buffer copied to current grid; pop = accumulator; gen_count increments.
  - State returns to IDLE; done=1 for exactly the following cycle.
- Timing:
  - start accepted at edge E0. Cells computed on edges E1..E(ROWS*COLS). Commit at edge E(ROWS*COLS+1).
  - busy is high from after E0 until after the commit edge: ROWS*COLS+1 cycles (65 for 8x8).
- Ignored inputs:
  - start while busy has no effect and is not queued.
  - wr_en while busy has no effect.
- rd_data always reflects the committed current grid, never the partially built next buffer.
  - rd_row >= ROWS returns 0.
- Width: s_k never exceeds 3; the 4-bit life sum never overflows; gen_count wraps silently.

Test Plan:
- Blinker: load row3=8'h1C, others 0; pulse start -> busy high exactly 65 cycles, single done pulse; rows 2,3,4 = 8'h08, others 0, pop=3, gen_count=1. Second start -> row3=8'h1C again, gen_count=2.
- Still life: rows 0,1 = 8'h03 (corner block) -> after a generation unchanged, pop=4.
- Edge/no-wrap: (0,0),(0,1),(1,0) alive, i.e. row0=8'h03, row1=8'h01 -> row0=8'h03, row1=8'h03, pop=4. Single cell at (0,0) only -> grid all 0, pop=0. Single cell at (7,7) must not affect (0,0).
- Busy protection: mid-COMPUTE assert start and wr_en (row0=8'hFF) -> no restart, grid result as if unasserted, exactly one done pulse.
- Reset mid-run: blinker loaded, start, drop rst_n at cycle 30 -> busy, done, gen_count, pop and all rows read 0 immediately. After release, start on the empty grid -> done after 65 cycles, pop=0.
- Simultaneous write+start: in IDLE, wr_en (row3=8'h1C) with start in the same cycle -> the generation uses the written row, giving the blinker result.

Source files
------------

// File: rtl/life_generation_ctrl.sv
// One Game of Life generation over a ROWS x COLS register grid, one cell per clock
// in raster order; the new generation is committed atomically and then done pulses.
module life_generation_ctrl #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int PW = $clog2(ROWS * COLS + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            wr_en,
  input  logic [RW-1:0]   wr_row,
  input  logic [COLS-1:0] wr_data,
  input  logic [RW-1:0]   rd_row,
  output logic [COLS-1:0] rd_data,
  output logic            busy,
  output logic            done,
  output logic [15:0]     gen_count,
  output logic [PW-1:0]   pop
);

  typedef enum logic [1:0] {IDLE, COMPUTE, COMMIT} state_t;

  state_t          state_q;
  logic [COLS-1:0] grid_q [ROWS];
  logic [COLS-1:0] nxt_q  [ROWS];
  logic [RW-1:0]   r_q;
  logic [CW-1:0]   c_q;
  logic [PW-1:0]   acc_q;
  logic [PW-1:0]   pop_q;
  logic [15:0]     gen_q;
  logic            done_q;

  logic [COLS-1:0] up, mid, dn;
  logic [1:0]      vs [COLS];
  logic [1:0]      s0, s1, s2;
  logic [3:0]      life;
  logic            next_bit;

  // Rows above/below the grid edge read as dead; no wrap-around.
  always_comb begin
    up  = (r_q != '0) ? grid_q[r_q - RW'(1)] : '0;
    mid = grid_q[r_q];
    dn  = (r_q != RW'(ROWS - 1)) ? grid_q[r_q + RW'(1)] : '0;
    for (int unsigned j = 0; j < COLS; j++) begin
      vs[j] = 2'(up[j]) + 2'(mid[j]) + 2'(dn[j]);
    end
    s0 = (c_q != '0) ? vs[c_q - CW'(1)] : '0;
    s1 = vs[c_q];
    s2 = (c_q != CW'(COLS - 1)) ? vs[c_q + CW'(1)] : '0;
    life = 4'(s0) + 4'(s1) + 4'(s2);
    next_bit = (life == 4'd3) || ((life == 4'd4) && mid[c_q]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      for (int unsigned i = 0; i < ROWS; i++) begin
        grid_q[i] <= '0;
        nxt_q[i]  <= '0;
      end
      r_q    <= '0;
      c_q    <= '0;
      acc_q  <= '0;
      pop_q  <= '0;
      gen_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (wr_en && (int'(wr_row) < ROWS)) grid_q[wr_row] <= wr_data;
          if (start) begin
            state_q <= COMPUTE;
            r_q     <= '0;
            c_q     <= '0;
            acc_q   <= '0;
          end
        end
        COMPUTE: begin
          nxt_q[r_q][c_q] <= next_bit;
          acc_q <= acc_q + PW'(next_bit);
          if (c_q == CW'(COLS - 1)) begin
            c_q <= '0;
            if (r_q == RW'(ROWS - 1)) state_q <= COMMIT;
            else r_q <= r_q + RW'(1);
          end else begin
            c_q <= c_q + CW'(1);
          end
        end
        COMMIT: begin
          grid_q  <= nxt_q;
          pop_q   <= acc_q;
          gen_q   <= gen_q + 16'd1;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_data   = (int'(rd_row) < ROWS) ? grid_q[rd_row] : '0;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign gen_count = gen_q;
  assign pop       = pop_q;

endmodule
